// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, instruction-memory read requests and a 2-entry decode queue.
// Optional misaligned-redirect trap (ERR state, sticky misalign) under FETCH_ALIGN_CHECK_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        misalign
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, ERR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1} state_t;
`endif

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [1:0]  count_reg;
  logic [31:0] q_inst [2];
  logic [31:0] q_pc   [2];
  logic        pop;
  logic        redirect_take;
  logic        bad_redirect;
  logic [1:0]  wr_idx;

  assign mem_addr   = {2'b00, pc_reg[31:2]};
  assign inst_valid = (count_reg != 2'd0);
  assign pop        = inst_valid && inst_ready;
  assign inst       = inst_valid ? q_inst[0] : 32'h0;
  assign inst_pc    = inst_valid ? q_pc[0]   : 32'h0;
  // Slot that receives a push once this cycle's pop has shifted the queue.
  assign wr_idx     = count_reg - {1'b0, pop};

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_reg;
  assign misalign      = misalign_reg;
  assign redirect_take = redirect && (state_reg != ERR);
  assign bad_redirect  = redirect_take && (redirect_pc[1:0] != 2'b00);
`else
  assign misalign      = 1'b0;
  assign redirect_take = redirect;
  assign bad_redirect  = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    mem_re     = 1'b0;
    case (state_reg)
      IDLE: begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (bad_redirect)
          state_next = ERR;
        else
`endif
        if (start)
          state_next = FETCH;
      end
      FETCH: begin
        mem_re = !redirect && ((count_reg < 2'd2) || pop);
`ifdef FETCH_ALIGN_CHECK_EN
        if (bad_redirect)
          state_next = ERR;
`endif
      end
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      count_reg <= 2'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (bad_redirect) begin
        count_reg <= 2'd0;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_reg <= 1'b1;
`endif
      end else if (redirect_take) begin
        pc_reg    <= {redirect_pc[31:2], 2'b00};
        count_reg <= 2'd0;
      end else begin
        count_reg <= count_reg - {1'b0, pop} + {1'b0, mem_re};
        if (mem_re)
          pc_reg <= pc_reg + 32'd4;
      end
    end
  end

  // Queue storage needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (pop) begin
      q_inst[0] <= q_inst[1];
      q_pc[0]   <= q_pc[1];
    end
    if (mem_re) begin
      q_inst[wr_idx[0]] <= mem_data;
      q_pc[wr_idx[0]]   <= pc_reg;
    end
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch front end: owns the program counter, issues read requests to the word-indexed instruction memory (`memory_inst`, combinational read) and buffers the returned words in a 2-entry queue for the decoder. The block is the requesting end of the instruction-memory read port. It presents instructions to the decoder over a valid/ready handshake and supports flush-and-redirect for taken branches.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address loaded into PC on reset; must be word-aligned.
- `clk`  in  1  clock, all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse; leaves IDLE and begins fetching
- `redirect`  in  1  flush queue and load PC from `redirect_pc`
- `redirect_pc`  in  32  byte-address branch/jump target
- `mem_addr`  out  32  word index to memory: `{2'b00, pc[31:2]}`
- `mem_re`  out  1  memory read enable
- `mem_data`  in  32  memory read data, valid in the same cycle as `mem_re`
- `inst`  out  32  head-of-queue instruction word
- `inst_pc`  out  32  byte address of `inst`
- `inst_valid`  out  1  queue non-empty
- `inst_ready`  in  1  decoder accepts head entry when high together with `inst_valid`
- `misalign`  out  1  sticky alignment error; tied 0 without the macro

## Operation
- States:
  - IDLE: after reset; no fetches.
  - FETCH: running.
  - ERR: only with the macro.
- IDLE→FETCH on `start`. In other states, `start` is ignored.
- `pop` = `inst_valid && inst_ready`.
- `mem_re` = FETCH && !`redirect` && (count<2 || `pop`). This signal is combinational.
- When `mem_re` is high, at posedge:
  - push {`pc`, `mem_data`} to the queue tail;
  - `pc` <= `pc` + 4, with modulo 2^32 wrap (32'hFFFF_FFFC → 0).
- A push and a pop in the same cycle leave count unchanged. When full with no pop, no fetch occurs and `pc` holds.
- Queue:
  - 2 entries, FIFO order, count 0..2;
  - `inst`/`inst_pc` show the head entry; they are 0 when empty.
- `redirect` has priority over push:
  - queue flushed (count <= 0), `pc` <= `redirect_pc`, no push.
  - A `pop` in the redirect cycle counts as consumed by the decoder.
  - `redirect` in IDLE only loads `pc`; the state stays IDLE.
- `rst` from any state, including mid-fetch or while full:
  - state IDLE, `pc` = `RESET_PC`, count 0;
  - `misalign` cleared.

## Timing
- Reset values:
  - `mem_re`, `inst_valid`, `misalign` = 0;
  - `inst`, `inst_pc` = 0;
  - `mem_addr` = `RESET_PC`>>2.
- `start` at cycle N → FETCH at N+1, first `mem_re` at N+1, `inst_valid` at N+2.
- Fetch-to-`inst_valid` latency: 1 cycle. Sustained throughput with `inst_ready` held high: 1 instruction/cycle.
- `redirect` at cycle N:
  - `inst_valid` = 0 at N+1;
  - first fetch from target at N+1;
  - target instruction valid at N+2.
- Backpressure: at most 2 fetches are outstanding beyond the decoder. Entries are never dropped or duplicated.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - `redirect` with `redirect_pc[1:0]` != 0 flushes the queue, enters ERR and sets `misalign`=1 at the next posedge.
  - ERR: `mem_re`=0, `inst_valid`=0; `start` and `redirect` are ignored until `rst`.
- Not defined:
  - `redirect_pc[1:0]` is ignored (`pc` loads `{redirect_pc[31:2],2'b00}`);
  - no ERR state; `misalign` is constant 0.

## Test plan
- Reset then `start`, `inst_ready`=1, memory words 0..3 = A,B,C,D → `inst` A,B,C,D on consecutive cycles with `inst_pc` 0,4,8,12. `mem_re` is first high the cycle after `start`.
- `inst_ready`=0 for 5 cycles after `start` → exactly 2 fetches (`mem_addr` 0,1), then `mem_re`=0 and `pc`=8. Raising `inst_ready` delivers A,B,C in order with no loss.
- `redirect` with `redirect_pc`=32'h40 while queue holds 2 entries → next cycle `inst_valid`=0; the following cycle `inst_pc`=32'h40 with `inst`=memory[16].
- `RESET_PC`=32'hFFFF_FFFC, `start` → `inst_pc` 32'hFFFF_FFFC then 32'h0 (wrap); `mem_addr` 32'h3FFF_FFFF then 0.
- Assert `rst` mid-stream with queue full → next cycle all outputs at reset values. A second `start` restarts from `RESET_PC`.
- With `FETCH_ALIGN_CHECK_EN`: `redirect_pc`=32'h6 → `misalign`=1, `mem_re` stays 0. A later `start` and `redirect` have no effect, and `rst` clears the error. Without the macro: `redirect_pc`=32'h6 → `inst_pc`=32'h4.
